mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator that sits between the CPU execute stage and the byte-addressed, big-endian data memory. Accepts byte/half/word load and store requests over a valid/ready handshake. Drives the memory's `MemRead`/`MemWrite` word interface and performs read-modify-write for sub-word stores. Returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

## Interface
Parameters:
- `ADDR_LIMIT`, 1024: size of the memory in bytes; an access with `addr + nbytes > ADDR_LIMIT` faults.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal (faults).
- `req_unsigned`  in  1  zero-extend loads when 1; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  misaligned, out-of-range or illegal-size access.
- `MemRead`  out  1  memory read enable.
- `MemWrite`  out  1  memory write enable.
- `mem_addr`  out  32  word-aligned byte address `{addr[31:2],2'b00}`; 0 when idle.
- `mem_wdata`  out  32  word written to memory; 0 when `MemWrite` is low.
- `mem_rdata`  in  32  combinational read word; valid in the same cycle `MemRead` is high.

## Operation
Memory convention:
- Big-endian: the byte at word base + k occupies bits `[31-8k -: 8]`.
- Memory writes all 4 bytes on the rising edge while `MemWrite` is high.

Request latching and checks:
- Request fields are latched on the accepting edge (`req_valid && req_ready`).
- Checks: half with `addr[0]=1`; word with `addr[1:0]!=0`; `req_size=11`; range test computed in 33 bits, so there is no wrap-around.

State machine (Moore; `MemRead`/`MemWrite` decode from state only and are never both high):
- IDLE: `req_ready=1`. On accept → FAULT_RSP if any check fails; else LOAD (load), STORE (word store) or RMW_RD (byte/half store).
- LOAD: `MemRead=1`. Extended data is registered at the edge → RESP.
- STORE: `MemWrite=1`, `mem_wdata=req_wdata` → RESP.
- RMW_RD: `MemRead=1`. Registers `mem_rdata` → RMW_WR.
- RMW_WR: `MemWrite=1`, `mem_wdata` = registered word with the lane replaced. Byte lane is `[31-8k -: 8]` with k = `addr[1:0]`. Half lane is [31:16] for offset 0, [15:0] for offset 2. → RESP.
- FAULT_RSP / RESP: `resp_valid=1`, `resp_fault` set only for FAULT_RSP. Held with all response fields stable until `resp_ready`; the next state is then IDLE.

Load extension:
- Byte: selected lane, sign-extended from bit 7, or zero-extended if `req_unsigned`.
- Half: selected lane, extended from bit 15.
- Word: passed through unchanged.

## Timing
- Reset (async assert): state = IDLE. Outputs: `req_ready=1`; `resp_valid=0`; `resp_fault=0`; `resp_rdata=0`; `MemRead=0`; `MemWrite=0`; `mem_addr=0`; `mem_wdata=0`.
- Reset mid-operation: enables drop immediately. An RMW whose write edge has not occurred leaves memory unchanged, and no response is produced.
- Latency from the accept edge E0 to `resp_valid` high (the cycle after that edge):
  - Fault: E0, zero memory cycles.
  - Load: E1, one `MemRead` cycle.
  - Word store: E1, one `MemWrite` cycle.
  - Sub-word store: E2, one `MemRead` cycle then one `MemWrite` cycle.
- Throughput: a new request is accepted no earlier than the cycle after the response handshake; there is no overlap.
- Requests are ignored while not in IDLE; `req_*` may change freely after acceptance.

## Test plan
- sw 0x11223344 to 0x10, then lw 0x10 → rdata 0x11223344, fault 0. Byte 0x10 = 0x11, byte 0x13 = 0x44. Exactly one `MemWrite` cycle, with `mem_addr=0x10`.
- Word 0x10 = 0x11223380: lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lh 0x10 → 0x00001122; lhu 0x12 → 0x00003380.
- sh 0xBEEF to 0x12 over 0x11223344 → word becomes 0x1122BEEF. Handshake sequence: one `MemRead` cycle, then one `MemWrite` cycle with `mem_wdata=0x1122BEEF`, and `resp_valid` two cycles after accept. Separately, sb 0xAA to 0x11 → 0x11AA3344.
- Each of the following faults with rdata 0 and no `MemRead`/`MemWrite` ever asserted: lw 0x11, lh 0x13, size=11, and sw 0x400 with `ADDR_LIMIT=1024`. In contrast, lw 0x3FC succeeds.
- `resp_ready` held low 3 cycles after a load → `resp_valid`, `resp_rdata` stable, `req_ready=0` throughout. A `req_valid` pulse in that window is ignored.
- `rst_n` low during RMW_WR (before the edge) → `MemWrite` falls immediately. Memory word stays 0x11223344 and no response follows reset release.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-memory bus shared by the load/store unit,
// its requester and the data memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output MemRead, MemWrite, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  MemRead, MemWrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a big-endian, word-organised data memory with
// read-modify-write for sub-word stores and fault detection before any access.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// LOAD      | MemRead high, extended load data captured at the edge
// STORE     | MemWrite high with the full store word
// RMW_RD    | MemRead high, current word captured and merged with the lane
// RMW_WR    | MemWrite high with the merged word
// FAULT_RSP | response with resp_fault set, held until resp_ready
// RESP      | normal response, held until resp_ready
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_FAULT_RSP,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        unsigned_q;
  logic [15:0] wdata_q;

  logic        req_ready_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        misaligned;
  logic        size_bad;
  logic        range_bad;
  logic        req_fault;
  logic        accept;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [15:0] data);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    res[31:24] = data[7:0];
        2'd1:    res[23:16] = data[7:0];
        2'd2:    res[15:8]  = data[7:0];
        default: res[7:0]   = data[7:0];
      endcase
    end else if (off[1]) begin
      res[15:0] = data;
    end else begin
      res[31:16] = data;
    end
    return res;
  endfunction

  // Range test is done one bit wider than the address so addresses near 2^32 cannot wrap.
  always_comb begin
    case (bus.req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr   = {1'b0, bus.req_addr} + {30'd0, nbytes};
    range_bad  = end_addr > 33'(ADDR_LIMIT);
    misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    size_bad   = (bus.req_size == 2'b11);
    req_fault  = misaligned || size_bad || range_bad;
    accept     = bus.req_valid && req_ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 16'd0;
      req_ready_q  <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            size_q      <= bus.req_size;
            off_q       <= bus.req_addr[1:0];
            unsigned_q  <= bus.req_unsigned;
            wdata_q     <= bus.req_wdata[15:0];
            req_ready_q <= 1'b0;
            if (req_fault) begin
              state_q      <= S_FAULT_RSP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              mem_addr_q <= {bus.req_addr[31:2], 2'b00};
              if (!bus.req_write) begin
                state_q    <= S_LOAD;
                mem_read_q <= 1'b1;
              end else if (bus.req_size == 2'b10) begin
                state_q     <= S_STORE;
                mem_write_q <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
              end else begin
                state_q    <= S_RMW_RD;
                mem_read_q <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          state_q      <= S_RESP;
          mem_read_q   <= 1'b0;
          mem_addr_q   <= 32'd0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_extend(bus.mem_rdata, size_q, off_q, unsigned_q);
        end
        S_RMW_RD: begin
          state_q     <= S_RMW_WR;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= merge_lane(bus.mem_rdata, size_q, off_q, wdata_q);
        end
        S_STORE, S_RMW_WR: begin
          state_q      <= S_RESP;
          mem_write_q  <= 1'b0;
          mem_wdata_q  <= 32'd0;
          mem_addr_q   <= 32'd0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'd0;
        end
        S_FAULT_RSP, S_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_addr_q   <= 32'd0;
          mem_wdata_q  <= 32'd0;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array memory model plus a response scoreboard.
module tb_mem_access_unit;
  localparam int unsigned ADDR_LIMIT = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          nrd;
    int          nwr;
    int          nboth;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_access_unit_if bus();

  mem_access_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    else if (pl_en)   mem[pl_idx] <= pl_val;
  end

  assign bus.mem_rdata = bus.MemRead ? mem[bus.mem_addr[9:2]] : 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q [$];

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = a[9:2]; pl_val = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request, scrambles req_* after acceptance, and observes until resp_valid.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [32:0] expv, output res_t r);
    int n;
    r.rdata = 32'h0; r.fault = 1'b0; r.lat = 0; r.nrd = 0; r.nwr = 0; r.nboth = 0;
    r.waddr = 32'h0; r.wdata = 32'h0;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = 32'hDEAD_BEE0; bus.req_wdata = ~wd;
    bus.req_size = ~sz; bus.req_unsigned = ~u; bus.req_write = ~w;
    while (1) begin
      @(negedge clk);
      if (bus.MemRead) r.nrd = r.nrd + 1;
      if (bus.MemWrite) begin
        r.nwr = r.nwr + 1; r.waddr = bus.mem_addr; r.wdata = bus.mem_wdata;
      end
      if (bus.MemRead && bus.MemWrite) r.nboth = r.nboth + 1;
      if (bus.resp_valid) break;
      r.lat = r.lat + 1;
      if (r.lat > 20) break;
    end
    r.rdata = bus.resp_rdata; r.fault = bus.resp_fault;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.MemRead, bus.MemWrite} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got rdy/vld/flt/rd/wr=%b, required 10000",
               {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.MemRead, bus.MemWrite});
    end
    n_cmp++;
    if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required all 0",
               bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    res_t r;
    logic [32:0] e;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, {1'b0, 32'h0}, r);
    e = exp_q.pop_front();
    n_cmp++;
    if ({r.fault, r.rdata} !== e) begin
      n_bad++; $display("FAIL sw_resp: got fault=%b rdata=%h, required %h", r.fault, r.rdata, e);
    end
    n_cmp++;
    if (r.lat != 1 || r.nrd != 0 || r.nwr != 1 || r.waddr !== 32'h10 || r.wdata !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL sw_bus: got lat=%0d rd=%0d wr=%0d addr=%h wdata=%h, required 1 0 1 00000010 11223344",
               r.lat, r.nrd, r.nwr, r.waddr, r.wdata);
    end
    n_cmp++;
    if (mem[4][31:24] !== 8'h11 || mem[4][7:0] !== 8'h44) begin
      n_bad++; $display("FAIL sw_bytes: got word=%h, required byte0=11 byte3=44", mem[4]);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'h1122_3344}, r);
    e = exp_q.pop_front();
    n_cmp++;
    if ({r.fault, r.rdata} !== e || r.lat != 1 || r.nrd != 1 || r.nwr != 0) begin
      n_bad++;
      $display("FAIL lw_resp: got fault=%b rdata=%h lat=%0d rd=%0d wr=%0d, required %h lat=1 rd=1 wr=0",
               r.fault, r.rdata, r.lat, r.nrd, r.nwr, e);
    end
    preload(32'h3FC, 32'hCAFE_F00D);
    issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, {1'b0, 32'hCAFE_F00D}, r);
    e = exp_q.pop_front();
    n_cmp++;
    if ({r.fault, r.rdata} !== e) begin
      n_bad++; $display("FAIL lw_top: got fault=%b rdata=%h, required %h", r.fault, r.rdata, e);
    end
  endtask

  task automatic test_load_extend();
    res_t r;
    logic [32:0] e;
    logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    logic        uns [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad  [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h12};
    logic [31:0] ex  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1122,
                             32'h0000_3380, 32'h0000_0011, 32'h0000_3380};
    preload(32'h10, 32'h1122_3380);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sz[i], uns[i], ad[i], 32'h0, {1'b0, ex[i]}, r);
      e = exp_q.pop_front();
      n_cmp++;
      if ({r.fault, r.rdata} !== e || r.lat != 1 || r.nwr != 0) begin
        n_bad++;
        $display("FAIL load_ext[%0d]: got fault=%b rdata=%h lat=%0d wr=%0d, required %h lat=1 wr=0",
                 i, r.fault, r.rdata, r.lat, r.nwr, e);
      end
    end
    preload(32'h20, 32'h8001_7F02);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, {1'b0, 32'hFFFF_8001}, r);
    e = exp_q.pop_front();
    n_cmp++;
    if ({r.fault, r.rdata} !== e) begin
      n_bad++; $display("FAIL lh_neg: got fault=%b rdata=%h, required %h", r.fault, r.rdata, e);
    end
  endtask

  task automatic test_subword_store();
    res_t r;
    logic [32:0] e;
    logic [1:0]  sz  [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    logic [31:0] ad  [4] = '{32'h12, 32'h11, 32'h10, 32'h13};
    logic [31:0] wd  [4] = '{32'h1234_BEEF, 32'h5555_55AA, 32'hFFFF_CAFE, 32'h0000_0177};
    logic [31:0] ex  [4] = '{32'h1122_BEEF, 32'h11AA_3344, 32'hCAFE_3344, 32'h1122_3377};
    for (int i = 0; i < 4; i++) begin
      preload(32'h10, 32'h1122_3344);
      issue(1'b1, sz[i], 1'b1, ad[i], wd[i], {1'b0, 32'h0}, r);
      e = exp_q.pop_front();
      n_cmp++;
      if ({r.fault, r.rdata} !== e) begin
        n_bad++; $display("FAIL rmw_resp[%0d]: got fault=%b rdata=%h, required %h", i, r.fault, r.rdata, e);
      end
      n_cmp++;
      if (r.lat != 2 || r.nrd != 1 || r.nwr != 1 || r.nboth != 0 || r.wdata !== ex[i] || r.waddr !== 32'h10) begin
        n_bad++;
        $display("FAIL rmw_bus[%0d]: got lat=%0d rd=%0d wr=%0d both=%0d addr=%h wdata=%h, required 2 1 1 0 00000010 %h",
                 i, r.lat, r.nrd, r.nwr, r.nboth, r.waddr, r.wdata, ex[i]);
      end
      n_cmp++;
      if (mem[4] !== ex[i]) begin
        n_bad++; $display("FAIL rmw_mem[%0d]: got %h, required %h", i, mem[4], ex[i]);
      end
    end
  endtask

  task automatic test_faults();
    res_t r;
    logic [32:0] e;
    logic        w  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  sz [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10};
    logic [31:0] ad [6] = '{32'h11, 32'h13, 32'h10, 32'h400, 32'h400, 32'hFFFF_FFFC};
    preload(32'h10, 32'h1122_3344);
    for (int i = 0; i < 6; i++) begin
      issue(w[i], sz[i], 1'b0, ad[i], 32'hA5A5_A5A5, {1'b1, 32'h0}, r);
      e = exp_q.pop_front();
      n_cmp++;
      if ({r.fault, r.rdata} !== e || r.lat != 0 || r.nrd != 0 || r.nwr != 0) begin
        n_bad++;
        $display("FAIL fault[%0d]: got fault=%b rdata=%h lat=%0d rd=%0d wr=%0d, required %h lat=0 rd=0 wr=0",
                 i, r.fault, r.rdata, r.lat, r.nrd, r.nwr, e);
      end
    end
    n_cmp++;
    if (mem[4] !== 32'h1122_3344) begin
      n_bad++; $display("FAIL fault_mem: got %h, required 11223344", mem[4]);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    int n;
    preload(32'h10, 32'h1122_3344);
    preload(32'h20, 32'h0BAD_F00D);
    exp_q.push_back({1'b0, 32'h1122_3344});
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h20;
    bus.req_wdata = 32'hDEAD_BEEF; bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.resp_valid, bus.req_ready, bus.resp_fault, bus.resp_rdata, bus.MemWrite} !==
          {3'b100, 32'h1122_3344, 1'b0}) begin
        n_bad++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b flt=%b rdata=%h wr=%b, required 1 0 0 11223344 0",
                 i, bus.resp_valid, bus.req_ready, bus.resp_fault, bus.resp_rdata, bus.MemWrite);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.resp_fault, bus.resp_rdata} !== e || !bus.resp_valid) begin
      n_bad++;
      $display("FAIL hold_resp: got vld=%b fault=%b rdata=%h, required 1 %h",
               bus.resp_valid, bus.resp_fault, bus.resp_rdata, e);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01 || mem[8] !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL hold_after: got vld=%b rdy=%b mem20=%h, required 0 1 0badf00d",
               bus.resp_valid, bus.req_ready, mem[8]);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int nv;
    preload(32'h10, 32'h1122_3344);
    @(posedge clk); #1;
    bus.req_write = 1'b1; bus.req_size = 2'b01; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h12; bus.req_wdata = 32'h0000_BEEF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.MemWrite !== 1'b1 || bus.mem_wdata !== 32'h1122_BEEF) begin
      n_bad++;
      $display("FAIL mid_rmw_wr: got wr=%b wdata=%h, required 1 1122beef", bus.MemWrite, bus.mem_wdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.MemWrite, bus.MemRead, bus.req_ready, bus.mem_wdata} !== {3'b001, 32'h0}) begin
      n_bad++;
      $display("FAIL mid_rmw_rst: got wr=%b rd=%b rdy=%b wdata=%h, required 0 0 1 0",
               bus.MemWrite, bus.MemRead, bus.req_ready, bus.mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid) nv++;
    end
    n_cmp++;
    if (mem[4] !== 32'h1122_3344 || nv != 0) begin
      n_bad++;
      $display("FAIL mid_rmw_after: got mem=%h resp_cycles=%0d, required 11223344 0", mem[4], nv);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b1;
    pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
    test_reset();
    test_word_store_load();
    test_load_extend();
    test_subword_store();
    test_faults();
    test_backpressure();
    test_reset_mid_rmw();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
